// File: rtl/levenshtein_search_engine.sv
// levenshtein_search_engine: Myers bit-parallel Levenshtein scan of an SRAM dictionary over Wishbone.
// Defining LEVENSHTEIN_EARLY_EXIT_EN stops the scan at the first zero-distance word.
module levenshtein_search_engine #(
  parameter int MASTER_ADDR_WIDTH = 24,
  parameter int SLAVE_ADDR_WIDTH = 24,
  parameter int BITVECTOR_WIDTH = 32,
  parameter int ID_WIDTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  output logic                         wbm_cyc_o,
  output logic                         wbm_stb_o,
  output logic [MASTER_ADDR_WIDTH-1:0] wbm_adr_o,
  output logic                         wbm_we_o,
  output logic [7:0]                   wbm_dat_o,
  input  logic                         wbm_ack_i,
  input  logic                         wbm_err_i,
  input  logic                         wbm_rty_i,
  input  logic [7:0]                   wbm_dat_i,
  input  logic                         wbs_cyc_i,
  input  logic                         wbs_stb_i,
  input  logic                         wbs_we_i,
  input  logic [SLAVE_ADDR_WIDTH-1:0]  wbs_adr_i,
  input  logic [7:0]                   wbs_dat_i,
  output logic                         wbs_ack_o,
  output logic                         wbs_err_o,
  output logic                         wbs_rty_o,
  output logic [7:0]                   wbs_dat_o,
  output logic [1:0]                   sram_config
);
  localparam int MAW = MASTER_ADDR_WIDTH;
  localparam int BW = BITVECTOR_WIDTH;
  localparam int BYTES = BW / 8;
  localparam int JW = $clog2(BYTES);
  localparam int JCW = JW > 0 ? JW : 1;
  localparam int LW = $clog2(BW);
  localparam logic [MAW-1:0] DICT_RST = MAW'(256 * BYTES * 2);
  typedef enum logic [1:0] {IDLE, READ_CHAR, READ_VEC, STEP} state_e;
  state_e state_q, state_d;
  logic cyc_q, cyc_d, ack_q, ack_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [1:0] sram_q, sram_d;
  logic [7:0] len_q, len_d, thr_q, thr_d, best_dist_q, best_dist_d, d_q, d_d, char_q, char_d;
  logic [LW-1:0] len_act_q, len_act_d;
  logic [MAW-1:0] start_q, start_d, ptr_q, ptr_d, pm_adr;
  logic [JCW-1:0] j_q, j_d;
  logic [BW-1:0] pm_q, pm_d, vp_q, vp_d, vn_q, vn_d;
  logic [ID_WIDTH-1:0] idx_q, idx_d, best_idx_q, best_idx_d;
  logic [15:0] cnt_q, cnt_d, best_idx16;
  logic [BW-1:0] d0, hp, hn, hp1, mask, mask_s;
  logic [23:0] start24;
  logic [3:0] a;
  logic wr, last, fault, unused_adr;
  assign a = wbs_adr_i[3:0];
  assign unused_adr = ^wbs_adr_i[SLAVE_ADDR_WIDTH-1:4];
  assign wr = wbs_cyc_i & wbs_stb_i & wbs_we_i & ~ack_q;
  assign last = j_q == JCW'(BYTES - 1);
  assign fault = cyc_q & (wbm_err_i | wbm_rty_i);
  assign start24 = 24'(start_q);
  assign best_idx16 = 16'(best_idx_q);
  assign pm_adr = MAW'((32'd1 << (8 + JW)) | (32'(char_q) << JW) | 32'(j_q));
  assign mask = BW'(1) << len_act_q;
  assign mask_s = BW'(1) << len_q[LW-1:0];
  // One Myers column step; bits above L carry junk upward only and never reach the mask bit.
  assign d0 = (((pm_q & vp_q) + vp_q) ^ vp_q) | pm_q | vn_q;
  assign hp = vn_q | ~(d0 | vp_q);
  assign hn = d0 & vp_q;
  assign hp1 = (hp << 1) | BW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cyc_q <= 1'b0;
      ack_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      sram_q <= '0;
      len_q <= '0;
      thr_q <= '0;
      best_dist_q <= 8'hFF;
      d_q <= '0;
      char_q <= '0;
      len_act_q <= '0;
      start_q <= DICT_RST;
      ptr_q <= DICT_RST;
      j_q <= '0;
      pm_q <= '0;
      vp_q <= '0;
      vn_q <= '0;
      idx_q <= '0;
      best_idx_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cyc_q <= cyc_d;
      ack_q <= ack_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      sram_q <= sram_d;
      len_q <= len_d;
      thr_q <= thr_d;
      best_dist_q <= best_dist_d;
      d_q <= d_d;
      char_q <= char_d;
      len_act_q <= len_act_d;
      start_q <= start_d;
      ptr_q <= ptr_d;
      j_q <= j_d;
      pm_q <= pm_d;
      vp_q <= vp_d;
      vn_q <= vn_d;
      idx_q <= idx_d;
      best_idx_q <= best_idx_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d = cyc_q;
    ack_d = wbs_cyc_i & wbs_stb_i & ~ack_q;
    busy_d = busy_q;
    done_d = done_q;
    err_d = err_q;
    sram_d = sram_q;
    len_d = len_q;
    thr_d = thr_q;
    best_dist_d = best_dist_q;
    d_d = d_q;
    char_d = char_q;
    len_act_d = len_act_q;
    start_d = start_q;
    ptr_d = ptr_q;
    j_d = j_q;
    pm_d = pm_q;
    vp_d = vp_q;
    vn_d = vn_q;
    idx_d = idx_q;
    best_idx_d = best_idx_q;
    cnt_d = cnt_q;
    case (state_q)
      READ_CHAR: begin
        if (!cyc_q) cyc_d = 1'b1;
        else if (fault) begin
          cyc_d = 1'b0;
          err_d = 1'b1;
          busy_d = 1'b0;
          state_d = IDLE;
        end else if (wbm_ack_i) begin
          cyc_d = 1'b0;
          ptr_d = ptr_q + MAW'(1);
          char_d = wbm_dat_i;
          if (wbm_dat_i == 8'h00) begin
            if (d_q < best_dist_q) begin
              best_dist_d = d_q;
              best_idx_d = idx_q;
            end
            if (d_q <= thr_q && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
            idx_d = idx_q + ID_WIDTH'(1);
            d_d = 8'(len_act_q) + 8'd1;
            vp_d = mask | (mask - BW'(1));
            vn_d = '0;
`ifdef LEVENSHTEIN_EARLY_EXIT_EN
            if (d_q == 8'd0) begin
              done_d = 1'b1;
              busy_d = 1'b0;
              state_d = IDLE;
            end
`endif
          end else if (wbm_dat_i == 8'h01) begin
            done_d = 1'b1;
            busy_d = 1'b0;
            state_d = IDLE;
          end else begin
            j_d = '0;
            pm_d = '0;
            state_d = READ_VEC;
          end
        end
      end
      READ_VEC: begin
        if (!cyc_q) cyc_d = 1'b1;
        else if (fault) begin
          cyc_d = 1'b0;
          err_d = 1'b1;
          busy_d = 1'b0;
          state_d = IDLE;
        end else if (wbm_ack_i) begin
          pm_d = pm_q | (BW'(wbm_dat_i) << (8 * (BYTES - 1 - int'(j_q))));
          j_d = j_q + JCW'(1);
          if (last) begin
            cyc_d = 1'b0;
            state_d = STEP;
          end
        end
      end
      STEP: begin
        vp_d = (hn << 1) | ~(d0 | hp1);
        vn_d = d0 & hp1;
        d_d = |(hp & mask) ? d_q + 8'd1 : |(hn & mask) ? d_q - 8'd1 : d_q;
        state_d = READ_CHAR;
      end
      default: ;
    endcase
    // Host writes override any master activity in the same cycle.
    if (wr) begin
      if (a == 4'd1) sram_d = wbs_dat_i[1:0];
      if (a == 4'd2) len_d = wbs_dat_i;
      if (a == 4'd3) thr_d = wbs_dat_i;
      if (a == 4'd9) start_d = MAW'({wbs_dat_i, start24[15:0]});
      if (a == 4'd10) start_d = MAW'({start24[23:16], wbs_dat_i, start24[7:0]});
      if (a == 4'd11) start_d = MAW'({start24[23:8], wbs_dat_i});
      if (a == 4'd0) begin
        cyc_d = 1'b0;
        busy_d = wbs_dat_i[0];
        state_d = wbs_dat_i[0] ? READ_CHAR : IDLE;
        if (wbs_dat_i[0]) begin
          ptr_d = start_q;
          len_act_d = len_q[LW-1:0];
          d_d = 8'(len_q[LW-1:0]) + 8'd1;
          vp_d = mask_s | (mask_s - BW'(1));
          vn_d = '0;
          idx_d = '0;
          best_dist_d = 8'hFF;
          best_idx_d = '0;
          cnt_d = '0;
          done_d = 1'b0;
          err_d = 1'b0;
        end
      end
    end
  end

  always_comb begin
    wbm_cyc_o = cyc_q;
    wbm_stb_o = cyc_q;
    wbm_adr_o = state_q == READ_VEC ? pm_adr : ptr_q;
    wbm_we_o = 1'b0;
    wbm_dat_o = 8'h00;
    wbs_ack_o = ack_q;
    wbs_err_o = 1'b0;
    wbs_rty_o = 1'b0;
    sram_config = sram_q;
    wbs_dat_o = 8'h00;
    case (a)
      4'd0: wbs_dat_o = {5'b0, err_q, done_q, busy_q};
      4'd1: wbs_dat_o = {6'b0, sram_q};
      4'd2: wbs_dat_o = len_q;
      4'd3: wbs_dat_o = thr_q;
      4'd4: wbs_dat_o = best_dist_q;
      4'd5: wbs_dat_o = best_idx16[15:8];
      4'd6: wbs_dat_o = best_idx16[7:0];
      4'd7: wbs_dat_o = cnt_q[15:8];
      4'd8: wbs_dat_o = cnt_q[7:0];
      4'd9: wbs_dat_o = start24[23:16];
      4'd10: wbs_dat_o = start24[15:8];
      4'd11: wbs_dat_o = start24[7:0];
      default: wbs_dat_o = 8'h00;
    endcase
  end
endmodule
